// File: rtl/bcp_select_var.sv
// bcp_select_var: decision unit of the hardware SAT/BCP engine.
// After a conflict-free BCP pass, the controller raises a request. This block
// then scans the assignment bitmask round-robin for the next unassigned
// variable. It commits that variable as a decision and tracks the decision
// level, or it reports SAT when every variable is already assigned.
// Optional feature macro: BCP_PHASE_SAVING_EN. When it is defined, a
// saved_phase port is added and supplies the decision polarity. When it is
// undefined, every decision takes the negative literal.
module bcp_select_var #(
    parameter int VAR_NUM   = 8,
    parameter int VAR_IDX_W = 3,
    parameter int LEVEL_W   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 select_var_request,
    input  logic [VAR_NUM-1:0]   var_assigned,
`ifdef BCP_PHASE_SAVING_EN
    input  logic [VAR_NUM-1:0]   saved_phase,
`endif
    input  logic                 backtrack,
    input  logic [LEVEL_W-1:0]   backtrack_level,
    output logic                 select_var_finish,
    output logic                 decide_valid,
    output logic [VAR_IDX_W-1:0] decide_var,
    output logic                 decide_value,
    output logic                 sat_found,
    output logic [LEVEL_W-1:0]   decision_level,
    output logic                 busy
);

    localparam int CNT_W = VAR_IDX_W + 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(VAR_NUM - 1);
    localparam logic [VAR_IDX_W-1:0] LAST_IDX = VAR_IDX_W'(VAR_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q;                      // request value seen last cycle
    logic [VAR_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       scan_ptr_q, scan_ptr_d;
    logic [CNT_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [VAR_IDX_W-1:0]   decide_var_q, decide_var_d;
    logic                   decide_value_q, decide_value_d;
    logic                   sat_q, sat_d;
    logic                   hit_q, hit_d;               // DONE was reached through a variable hit
    logic [LEVEL_W-1:0]     level_q, level_d;

    logic                   accept;
    logic [VAR_IDX_W-1:0]   scan_idx;
    logic                   phase_bit;

    assign scan_idx = scan_ptr_q[VAR_IDX_W-1:0];
    assign accept   = (state_q == IDLE) && select_var_request && !req_q;

`ifdef BCP_PHASE_SAVING_EN
    assign phase_bit = saved_phase[scan_idx];
`else
    assign phase_bit = 1'b0;
`endif

    // Next-state logic: scan sequencing, decision commit, SAT detection, backtrack.
    always_comb begin
        // NOTE: Every signal gets its default value first. Without this, a path that skips an assignment infers a latch.
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        scan_ptr_d     = scan_ptr_q;
        scan_cnt_d     = scan_cnt_q;
        decide_var_d   = decide_var_q;
        decide_value_d = decide_value_q;
        sat_d          = sat_q;
        hit_d          = hit_q;
        level_d        = level_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SCAN;
                    scan_ptr_d = {1'b0, rr_ptr_q};
                    scan_cnt_d = '0;
                    sat_d      = 1'b0;
                    hit_d      = 1'b0;
                end
            end
            SCAN: begin
                if (backtrack) begin
                    // An aborted scan leaves every output untouched.
                    state_d = IDLE;
                end else if (!var_assigned[scan_idx]) begin
                    decide_var_d   = scan_idx;
                    decide_value_d = phase_bit;
                    rr_ptr_d       = (scan_idx == LAST_IDX) ? '0 : scan_idx + VAR_IDX_W'(1);
                    if (level_q != '1) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    hit_d   = 1'b1;
                    state_d = DONE;
                end else if (scan_cnt_q == LAST_CNT) begin
                    sat_d   = 1'b1;
                    hit_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    scan_ptr_d = (scan_ptr_q == LAST_CNT) ? '0 : scan_ptr_q + CNT_W'(1);
                    scan_cnt_d = scan_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A backtrack always wins over an increment in the same cycle.
        if (backtrack) begin
            level_d = backtrack_level;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            req_q          <= 1'b0;
            rr_ptr_q       <= '0;
            scan_ptr_q     <= '0;
            scan_cnt_q     <= '0;
            decide_var_q   <= '0;
            decide_value_q <= 1'b0;
            sat_q          <= 1'b0;
            hit_q          <= 1'b0;
            level_q        <= '0;
        end else begin
            // NOTE: Sequential state uses non-blocking assignments. Every register therefore samples values from before the edge.
            state_q        <= state_d;
            req_q          <= select_var_request;
            rr_ptr_q       <= rr_ptr_d;
            scan_ptr_q     <= scan_ptr_d;
            scan_cnt_q     <= scan_cnt_d;
            decide_var_q   <= decide_var_d;
            decide_value_q <= decide_value_d;
            sat_q          <= sat_d;
            hit_q          <= hit_d;
            level_q        <= level_d;
        end
    end

    assign select_var_finish = (state_q == DONE);
    assign decide_valid      = (state_q == DONE) && hit_q;
    assign busy              = (state_q == SCAN) || (state_q == DONE);
    assign decide_var        = decide_var_q;
    assign decide_value      = decide_value_q;
    assign sat_found         = sat_q;
    assign decision_level    = level_q;

endmodule

// File: tb/tb_bcp_select_var.sv
// Testbench for bcp_select_var (VAR_NUM=8, LEVEL_W=4). A reference model
// computes the expected outcome of each request when the request is driven
// and queues it. The entry is popped when select_var_finish is observed.
module tb_bcp_select_var;

    localparam int VAR_NUM   = 8;
    localparam int VAR_IDX_W = 3;
    localparam int LEVEL_W   = 4;
    localparam int MAX_WAIT  = 40;

    logic                 clock;
    logic                 reset;
    logic                 select_var_request;
    logic [VAR_NUM-1:0]   var_assigned;
    logic [VAR_NUM-1:0]   saved_phase;
    logic                 backtrack;
    logic [LEVEL_W-1:0]   backtrack_level;
    logic                 select_var_finish;
    logic                 decide_valid;
    logic [VAR_IDX_W-1:0] decide_var;
    logic                 decide_value;
    logic                 sat_found;
    logic [LEVEL_W-1:0]   decision_level;
    logic                 busy;

    bcp_select_var #(
        .VAR_NUM   (VAR_NUM),
        .VAR_IDX_W (VAR_IDX_W),
        .LEVEL_W   (LEVEL_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .select_var_request (select_var_request),
        .var_assigned       (var_assigned),
`ifdef BCP_PHASE_SAVING_EN
        .saved_phase        (saved_phase),
`endif
        .backtrack          (backtrack),
        .backtrack_level    (backtrack_level),
        .select_var_finish  (select_var_finish),
        .decide_valid       (decide_valid),
        .decide_var         (decide_var),
        .decide_value       (decide_value),
        .sat_found          (sat_found),
        .decision_level     (decision_level),
        .busy               (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int   lat;
        logic valid;
        logic sat;
        int   var_idx;
        logic value;
        int   level;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_rr  = 0;   // model round-robin pointer
    int   m_lvl = 0;   // model decision level

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: it predicts one request outcome and advances the model state.
    function automatic exp_t predict(input logic [VAR_NUM-1:0] asg);
        exp_t e;
        int   idx;
        e.lat = VAR_NUM; e.valid = 1'b0; e.sat = 1'b1; e.var_idx = 0; e.value = 1'b0;
        for (int k = 0; k < VAR_NUM; k++) begin
            idx = (m_rr + k) % VAR_NUM;
            if (e.sat && !asg[idx]) begin
                e.sat = 1'b0; e.valid = 1'b1; e.lat = k + 1; e.var_idx = idx;
`ifdef BCP_PHASE_SAVING_EN
                e.value = saved_phase[idx];
`else
                e.value = 1'b0;
`endif
            end
        end
        if (e.valid) begin
            m_rr = (e.var_idx + 1) % VAR_NUM;
            if (m_lvl < (1 << LEVEL_W) - 1) m_lvl++;
        end
        e.level = m_lvl;
        return e;
    endfunction

    // Issue one request and wait for finish, bounded by MAX_WAIT cycles.
    // drop_early lowers the request right after acceptance.
    // hold keeps it high for extra cycles after finish, to check that no retrigger occurs.
    task automatic run_req(input logic [VAR_NUM-1:0] asg, input bit drop_early, input int hold);
        exp_t e;
        int   cnt;
        bit   got;
        @(negedge clock);
        var_assigned = asg;
        sb.push_back(predict(asg));
        select_var_request = 1'b1;
        @(posedge clock);                      // accepting edge E0
        if (drop_early) begin
            @(negedge clock);
            select_var_request = 1'b0;
        end
        cnt = 0;
        got = 1'b0;
        while (cnt < MAX_WAIT && !got) begin
            @(posedge clock); #1;
            cnt++;
            if (select_var_finish) got = 1'b1;
        end
        check("finish_seen", 32'(got), 32'd1);
        e = sb.pop_front();
        check("latency", 32'(cnt), 32'(e.lat));
        check("decide_valid", 32'(decide_valid), 32'(e.valid));
        check("sat_found", 32'(sat_found), 32'(e.sat));
        check("decision_level", 32'(decision_level), 32'(e.level));
        check("busy_done", 32'(busy), 32'd1);
        if (e.valid) begin
            check("decide_var", 32'(decide_var), 32'(e.var_idx));
            check("decide_value", 32'(decide_value), 32'(e.value));
        end
        @(posedge clock); #1;
        check("finish_one_cycle", 32'(select_var_finish), 32'd0);
        check("valid_one_cycle", 32'(decide_valid), 32'd0);
        check("sat_held", 32'(sat_found), 32'(e.sat));
        if (e.valid) check("decide_var_held", 32'(decide_var), 32'(e.var_idx));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("no_retrigger", 32'({busy, select_var_finish}), 32'd0);
        end
        @(negedge clock);
        select_var_request = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int fin_cnt;
        reset              = 1'b0;
        select_var_request = 1'b0;
        var_assigned       = '0;
        saved_phase        = 8'b0000_1000;
        backtrack          = 1'b0;
        backtrack_level    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_outputs", 32'({select_var_finish, decide_valid, decide_var, decide_value,
                                  sat_found, decision_level, busy}), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic decision: first free variable is 3, with rr_ptr at 0.
        run_req(8'b0000_0111, 1'b0, 3);
        // Wrap-around: the scan runs from 4 to 0.
        run_req(8'b1111_1110, 1'b0, 0);
        // SAT, with the request dropped mid-scan, which must not abort the scan.
        run_req(8'hFF, 1'b1, 0);
        // Three more decisions reach level 5.
        for (int i = 0; i < 3; i++) run_req(8'h00, 1'b0, 0);
        check("level_before_bt", 32'(decision_level), 32'd5);

        // Backtrack to level 2 during cycle 2 of a scan.
        @(negedge clock);
        var_assigned       = 8'hFF;
        select_var_request = 1'b1;
        @(posedge clock);                      // E0
        @(posedge clock);                      // scan cycle 1 completes
        @(negedge clock);
        backtrack       = 1'b1;
        backtrack_level = 4'd2;
        @(negedge clock);
        backtrack = 1'b0;
        select_var_request = 1'b0;
        m_lvl = 2;
        fin_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (select_var_finish) fin_cnt++;
        end
        check("bt_no_finish", 32'(fin_cnt), 32'd0);
        check("bt_idle", 32'(busy), 32'd0);
        check("bt_level", 32'(decision_level), 32'd2);

        // Sixteen decisions: the level saturates at 15.
        for (int i = 0; i < 16; i++) run_req(8'h00, 1'b0, 0);
        check("level_saturated", 32'(decision_level), 32'd15);

        // Reset asserted mid-scan.
        @(negedge clock);
        var_assigned       = 8'hFF;
        select_var_request = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        select_var_request = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({select_var_finish, decide_valid, decide_var, decide_value,
                                      sat_found, decision_level, busy}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        m_rr  = 0;
        m_lvl = 0;
        // After reset, the scan starts at index 0. saved_phase selects polarity only when phase saving is built in.
        run_req(8'b0000_0111, 1'b0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcp_select_var.md
# bcp_select_var

Decision unit for the hardware SAT/BCP engine. It sits directly downstream of the BCP/conflict-analysis controller. It starts when the controller raises `select_var_request` after a conflict-free BCP pass. It scans the assignment bitmask round-robin for the next unassigned variable, commits it as a decision and tracks the decision level. It returns a one-cycle `select_var_finish` pulse, with `sat_found` set if every variable is already assigned.

## Interface
Parameters:
- `VAR_NUM`, 8: number of variables; must be ≥2.
- `VAR_IDX_W`, 3: variable index width; must equal clog2(`VAR_NUM`).
- `LEVEL_W`, 4: decision level counter width.

Ports:
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `select_var_request`  in  1  level request from controller; a new selection starts only on its 0→1 transition.
- `var_assigned`  in  `VAR_NUM`  bit i=1 means variable i is assigned; must be stable while busy.
- `saved_phase`  in  `VAR_NUM`  preferred polarity per variable; present only with `BCP_PHASE_SAVING_EN`.
- `backtrack`  in  1  one-cycle pulse that loads the decision level.
- `backtrack_level`  in  `LEVEL_W`  target level, sampled when `backtrack`=1.
- `select_var_finish`  out  1  one-cycle completion pulse.
- `decide_valid`  out  1  one-cycle pulse with finish when a variable was chosen.
- `decide_var`  out  `VAR_IDX_W`  chosen variable; held until the next accepted request.
- `decide_value`  out  1  polarity assigned to `decide_var`; held like `decide_var`.
- `sat_found`  out  1  all variables assigned; held until the next accepted request.
- `decision_level`  out  `LEVEL_W`  current decision level (registered).
- `busy`  out  1  high in SCAN and DONE.

## Operation
- Registers:
  - `req_d`: previous request value.
  - `rr_ptr`: round-robin start index, reset 0.
  - `scan_ptr`, `scan_cnt`: scan position and count, width clog2(`VAR_NUM`)+1.
- A request is accepted when the FSM is in IDLE, `select_var_request`=1 and `req_d`=0.
- IDLE: on accept → SCAN; load `scan_ptr`=`rr_ptr`, `scan_cnt`=0; clear `sat_found`.
- SCAN: each cycle, test `var_assigned[scan_ptr]` combinationally.
  - If 0: latch `decide_var`=`scan_ptr` and `decide_value`; set `rr_ptr`=(`scan_ptr`+1) mod `VAR_NUM`; increment `decision_level`, saturating at 2^`LEVEL_W`−1; → DONE with `decide_valid` pending.
  - If 1 and `scan_cnt`=`VAR_NUM`−1: set `sat_found`=1; `decision_level` and `rr_ptr` unchanged; → DONE.
  - Otherwise: `scan_ptr` wraps from `VAR_NUM`−1 to 0; increment `scan_cnt`.
- DONE: `select_var_finish`=1 for exactly one cycle; `decide_valid`=1 only for a variable hit; → IDLE.
- Backtrack:
  - `backtrack`=1 in any state loads `decision_level`=`backtrack_level`.
  - If it occurs in SCAN, the scan aborts → IDLE with no finish pulse and no output update.
  - Backtrack beats a same-cycle decision commit.
- Request dropping mid-scan does not abort the scan.
- Reset mid-operation → IDLE; all registers return to reset values.

## Timing
- Reset values:
  - Outputs `select_var_finish`, `decide_valid`, `decide_var`, `decide_value`, `sat_found`, `decision_level`, `busy` = 0.
  - Internal `rr_ptr`=0, `req_d`=0.
- Let the accepting edge be E0. If the first unassigned variable is k positions after `rr_ptr` (k=0..`VAR_NUM`−1), finish is high in the cycle after edge E0+k+1, i.e. latency k+1.
- All-assigned case: finish at latency `VAR_NUM`.
- `decision_level` updates on the same edge that enters DONE.
- Minimum spacing between accepted requests: request must be low for ≥1 sampled cycle.

## Configuration
- `BCP_PHASE_SAVING_EN` defined: the `saved_phase` port exists; `decide_value`=`saved_phase[decide_var]`, sampled at commit.
- Not defined: no `saved_phase` port; `decide_value` is always 0 (negative literal).

## Test plan
- Reset check: assert `reset`=0 mid-scan → all outputs 0, FSM IDLE, next request scans from index 0.
- Basic decision: `VAR_NUM`=8, `var_assigned`=8'b0000_0111, `rr_ptr`=0, request rise → finish at latency 4; `decide_var`=3, `decide_value`=0, `decide_valid`=1, `decision_level` 0→1, `rr_ptr`=4.
- Wrap-around: `rr_ptr`=4, `var_assigned`=8'b1111_1110 → scans 4,5,6,7,0; finish at latency 5; `decide_var`=0, `rr_ptr`=1.
- SAT: `var_assigned`=8'hFF → finish at latency 8; `sat_found`=1, `decide_valid`=0, `decision_level` unchanged.
- Backtrack: at level 5, pulse `backtrack` with level 2 during cycle 2 of a scan → no finish, FSM IDLE, `decision_level`=2. Separately, 16 decisions with `LEVEL_W`=4 → `decision_level` stays 15.
- Phase saving: with `BCP_PHASE_SAVING_EN`, `saved_phase`=8'b0000_1000 and `var_assigned`=8'b0000_0111 → `decide_var`=3, `decide_value`=1. Without the macro → `decide_value`=0.
